// File: rtl/fp_multi_pkg.sv
// Shared constants, operand classes and helpers for the parametrised FP multiplier.
package fp_multi_pkg;

   localparam int NV = 3;
   localparam int OF = 2;
   localparam int UF = 1;
   localparam int NX = 0;

   // Helpers take fields zero-extended to these maxima plus the real widths.
   localparam int MAX_EXP_W = 16;
   localparam int MAX_MAN_W = 64;
   localparam int MAX_W     = 1 + MAX_EXP_W + MAX_MAN_W;

   typedef enum logic [2:0] {ZERO, SUB, NORM, INF, QNAN, SNAN} fp_class_e;

   typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF, SP_ZERO} special_e;

   function automatic fp_class_e classify(input logic [MAX_EXP_W-1:0] exp_f,
                                          input logic [MAX_MAN_W-1:0] frac_f,
                                          input int                   exp_w,
                                          input int                   man_w);
      if (exp_f == '0)
         return (frac_f == '0) ? ZERO : SUB;
      else if (exp_f != ((MAX_EXP_W'(1) << exp_w) - MAX_EXP_W'(1)))
         return NORM;
      else if (frac_f == '0)
         return INF;
      else if (((frac_f >> (man_w - 1)) & MAX_MAN_W'(1)) != '0)
         return QNAN;
      else
         return SNAN;
   endfunction

   function automatic logic [MAX_W-1:0] canon_nan(input int exp_w, input int man_w);
      logic [MAX_W-1:0] one;
      one = MAX_W'(1);
      return (((one << exp_w) - one) << man_w) | (one << (man_w - 1));
   endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input reports WIDTH.
module fp_lzc #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0]           din,
   output logic [$clog2(WIDTH+1)-1:0] count
);
   localparam int CNT_W = $clog2(WIDTH + 1);

   // Scanning upward lets the highest set bit win.
   always_comb begin
      count = CNT_W'(WIDTH);
      for (int i = 0; i < WIDTH; i++) begin
         if (din[i])
            count = CNT_W'(WIDTH - 1 - i);
      end
   end

endmodule

// File: rtl/fp_multi_pipe.sv
// Four-stage IEEE-754 multiplier: unpack/multiply, normalise, subnormal shift and
// round, then pack with special-operand override into the output register.
module fp_multi_pipe
   import fp_multi_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter int TAG_W = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [EXP_W+MAN_W:0] in_a,
   input  logic [EXP_W+MAN_W:0] in_b,
   input  logic [TAG_W-1:0]     in_tag,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [EXP_W+MAN_W:0] out_y,
   output logic [TAG_W-1:0]     out_tag,
   output logic [3:0]           out_flags
);
   localparam int W      = 1 + EXP_W + MAN_W;
   localparam int BIAS   = 2**(EXP_W-1) - 1;
   localparam int SIG_W  = MAN_W + 1;
   localparam int PROD_W = 2*MAN_W + 2;
   localparam int EW     = EXP_W + 3;
   localparam int LZ_W   = $clog2(PROD_W + 1);

   localparam logic signed [EW-1:0] E_ONE  = EW'(1);
   localparam logic signed [EW-1:0] E_BIAS = EW'(BIAS);
   localparam logic signed [EW-1:0] E_MAX  = EW'(2**EXP_W - 1);
   localparam logic [W-1:0]         QNAN_Y = W'(canon_nan(EXP_W, MAN_W));

   // exp is a signed biased exponent for a significand with its MSB at the top of prod.
   typedef struct packed {
      logic              valid;
      logic [TAG_W-1:0]  tag;
      logic              sign;
      special_e          spc;
      logic              nv;
      logic [EW-1:0]     exp;
      logic [PROD_W-1:0] prod;
   } mul_stage_t;

   typedef struct packed {
      logic              valid;
      logic [TAG_W-1:0]  tag;
      logic              sign;
      special_e          spc;
      logic              nv;
      logic [EW-1:0]     exp;
      logic [SIG_W-1:0]  mant;
      logic              nx;
      logic              tiny;
   } rnd_stage_t;

   mul_stage_t s1_d, s1_q, s2_d, s2_q;
   rnd_stage_t s3_d, s3_q;

   logic             out_valid_d, out_valid_q;
   logic [W-1:0]     out_y_d, out_y_q;
   logic [TAG_W-1:0] out_tag_d, out_tag_q;
   logic [3:0]       out_flags_d, out_flags_q;

   logic stall;
   logic adv;

   assign stall    = out_valid_q && !out_ready;
   assign adv      = !stall;
   assign in_ready = !rst && !stall;

   logic [EXP_W-1:0] a_exp, b_exp;
   logic [MAN_W-1:0] a_frac, b_frac;
   fp_class_e        a_cls, b_cls;
   logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, inf_x_zero;
   logic [EW-1:0]    a_eff, b_eff;

   always_comb begin
      a_exp      = in_a[W-2 -: EXP_W];
      b_exp      = in_b[W-2 -: EXP_W];
      a_frac     = in_a[MAN_W-1:0];
      b_frac     = in_b[MAN_W-1:0];
      a_cls      = classify(MAX_EXP_W'(a_exp), MAX_MAN_W'(a_frac), EXP_W, MAN_W);
      b_cls      = classify(MAX_EXP_W'(b_exp), MAX_MAN_W'(b_frac), EXP_W, MAN_W);
      a_nan      = (a_cls == QNAN) || (a_cls == SNAN);
      b_nan      = (b_cls == QNAN) || (b_cls == SNAN);
      a_inf      = (a_cls == INF);
      b_inf      = (b_cls == INF);
      a_zero     = (a_cls == ZERO);
      b_zero     = (b_cls == ZERO);
      inf_x_zero = (a_inf && b_zero) || (a_zero && b_inf);
      a_eff      = (a_exp == '0) ? EW'(1) : EW'(a_exp);
      b_eff      = (b_exp == '0) ? EW'(1) : EW'(b_exp);

      s1_d = s1_q;
      if (adv) begin
         s1_d.valid = in_valid && in_ready;
         s1_d.tag   = in_tag;
         s1_d.sign  = in_a[W-1] ^ in_b[W-1];
         s1_d.nv    = (a_cls == SNAN) || (b_cls == SNAN) || inf_x_zero;
         if (a_nan || b_nan || inf_x_zero)
            s1_d.spc = SP_NAN;
         else if (a_inf || b_inf)
            s1_d.spc = SP_INF;
         else if (a_zero || b_zero)
            s1_d.spc = SP_ZERO;
         else
            s1_d.spc = SP_NONE;
         // +1 because the product's integer part occupies two bits
         s1_d.exp  = a_eff + b_eff - E_BIAS + E_ONE;
         s1_d.prod = PROD_W'({a_exp != '0, a_frac}) * PROD_W'({b_exp != '0, b_frac});
      end
   end

   logic [LZ_W-1:0] lz;

   fp_lzc #(.WIDTH(PROD_W)) u_lzc (
      .din   (s1_q.prod),
      .count (lz)
   );

   always_comb begin
      s2_d = s2_q;
      if (adv) begin
         s2_d      = s1_q;
         s2_d.prod = s1_q.prod << lz;
         s2_d.exp  = s1_q.exp - EW'(lz);
      end
   end

   logic signed [EW-1:0] e2;
   logic signed [EW-1:0] e3;
   logic                 tiny;
   logic [EW-1:0]        sh;
   logic [PROD_W-1:0]    shifted;
   logic                 sh_sticky, guard, sticky, inc;
   logic [SIG_W-1:0]     kept;
   logic [SIG_W:0]       rnd;

   always_comb begin
      e2   = $signed(s2_q.exp);
      tiny = e2 < E_ONE;
      sh   = tiny ? E_ONE - e2 : '0;
      e3   = tiny ? E_ONE : e2;
      // Oversized shifts empty the significand and leave everything in sticky.
      shifted   = s2_q.prod >> sh;
      sh_sticky = |(s2_q.prod & ~({PROD_W{1'b1}} << sh));
      kept      = shifted[PROD_W-1 -: SIG_W];
      guard     = shifted[MAN_W];
      sticky    = (|shifted[MAN_W-1:0]) || sh_sticky;
      inc       = guard && (sticky || kept[0]);
      rnd       = {1'b0, kept} + (SIG_W+1)'(inc);

      s3_d = s3_q;
      if (adv) begin
         s3_d.valid = s2_q.valid;
         s3_d.tag   = s2_q.tag;
         s3_d.sign  = s2_q.sign;
         s3_d.spc   = s2_q.spc;
         s3_d.nv    = s2_q.nv;
         s3_d.tiny  = tiny;
         s3_d.nx    = guard || sticky;
         if (rnd[SIG_W]) begin
            s3_d.mant = rnd[SIG_W:1];
            s3_d.exp  = e3 + E_ONE;
         end else begin
            s3_d.mant = rnd[SIG_W-1:0];
            s3_d.exp  = e3;
         end
      end
   end

   logic signed [EW-1:0] e4;
   logic                 ovf;
   logic [EXP_W-1:0]     exp_field;

   always_comb begin
      e4        = $signed(s3_q.exp);
      ovf       = e4 >= E_MAX;
      // A clear hidden bit after rounding means the result stayed subnormal.
      exp_field = s3_q.mant[MAN_W] ? e4[EXP_W-1:0] : '0;

      out_valid_d = out_valid_q;
      out_y_d     = out_y_q;
      out_tag_d   = out_tag_q;
      out_flags_d = out_flags_q;
      if (adv) begin
         out_valid_d = s3_q.valid;
         out_tag_d   = s3_q.tag;
         out_flags_d = '0;
         case (s3_q.spc)
            SP_NAN: begin
               out_y_d         = QNAN_Y;
               out_flags_d[NV] = s3_q.nv;
            end
            SP_INF:  out_y_d = {s3_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            SP_ZERO: out_y_d = {s3_q.sign, {(W-1){1'b0}}};
            default: begin
               if (ovf) begin
                  out_y_d         = {s3_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                  out_flags_d[OF] = 1'b1;
                  out_flags_d[NX] = 1'b1;
               end else begin
                  out_y_d         = {s3_q.sign, exp_field, s3_q.mant[MAN_W-1:0]};
                  out_flags_d[UF] = s3_q.tiny && s3_q.nx;
                  out_flags_d[NX] = s3_q.nx;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q        <= '0;
         s2_q        <= '0;
         s3_q        <= '0;
         out_valid_q <= 1'b0;
         out_y_q     <= '0;
         out_tag_q   <= '0;
         out_flags_q <= '0;
      end else begin
         s1_q        <= s1_d;
         s2_q        <= s2_d;
         s3_q        <= s3_d;
         out_valid_q <= out_valid_d;
         out_y_q     <= out_y_d;
         out_tag_q   <= out_tag_d;
         out_flags_q <= out_flags_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_y     = out_y_q;
   assign out_tag   = out_tag_q;
   assign out_flags = out_flags_q;

endmodule

// File: tb/tb_fp_multi_pipe.sv
// Directed-vector bench for fp_multi_pipe in the FP32 configuration.
module tb_fp_multi_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_a, in_b, out_y;
   logic [3:0]  in_tag, out_tag, out_flags;

   int n_checks = 0;
   int n_pass   = 0;

   // out_ready pattern 1,0,0,0,1,1,0 repeating; bit i is cycle i
   logic [6:0] bp_pat = 7'b0110001;

   typedef struct {
      string       nm;
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  tg;
      logic [31:0] y;
      logic [3:0]  fl;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   fp_multi_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_y     (out_y),
      .out_tag   (out_tag),
      .out_flags (out_flags)
   );

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
   endtask

   task automatic add_vec(input string nm, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] tg, input logic [31:0] y, input logic [3:0] fl);
      vec_t v;
      v.nm = nm; v.a = a; v.b = b; v.tg = tg; v.y = y; v.fl = fl;
      vecs.push_back(v);
   endtask

   task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] tg, input logic [31:0] ey, input logic [3:0] ef);
      int cyc;
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_a      = a;
      in_b      = b;
      in_tag    = tg;
      #1;
      check_eq({nm, "_rdy"}, 64'(in_ready), 64'd1);
      cyc = 0;
      do begin
         @(negedge clk);
         in_valid = 1'b0;
         cyc++;
      end while (!out_valid && cyc < 12);
      check_eq({nm, "_lat"}, 64'(cyc), 64'd4);
      check_eq({nm, "_y"}, 64'(out_y), 64'(ey));
      check_eq({nm, "_tag"}, 64'(out_tag), 64'(tg));
      check_eq({nm, "_flags"}, 64'(out_flags), 64'(ef));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int issued, head, cyc, extra, stale;

      rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1;

      //        name           a             b             tag   result        {NV,OF,UF,NX}
      add_vec("basic",      32'h40400000, 32'h40000000, 4'd5, 32'h40C00000, 4'b0000);
      add_vec("inf_x_zero", 32'h7F800000, 32'h00000000, 4'd1, 32'h7FC00000, 4'b1000);
      add_vec("snan",       32'h7F800001, 32'h3F800000, 4'd2, 32'h7FC00000, 4'b1000);
      add_vec("qnan",       32'h7FC00001, 32'h3F800000, 4'd3, 32'h7FC00000, 4'b0000);
      add_vec("neg_inf",    32'hFF800000, 32'h40000000, 4'd4, 32'hFF800000, 4'b0000);
      add_vec("inf_x_sub",  32'h7F800000, 32'h00000001, 4'd6, 32'h7F800000, 4'b0000);
      add_vec("zero_neg",   32'h00000000, 32'hC0000000, 4'd7, 32'h80000000, 4'b0000);
      add_vec("ovf",        32'h7F7FFFFF, 32'h40000000, 4'd8, 32'h7F800000, 4'b0101);
      add_vec("rne",        32'h3F800001, 32'h3F800001, 4'd9, 32'h3F800002, 4'b0001);
      add_vec("sub_half",   32'h00800000, 32'h3F000000, 4'd10, 32'h00400000, 4'b0000);
      add_vec("sub_tie",    32'h00000001, 32'h3F000000, 4'd11, 32'h00000000, 4'b0011);
      add_vec("sub_up",     32'h00000003, 32'h3F000000, 4'd12, 32'h00000002, 4'b0011);
      add_vec("sub_minnrm", 32'h00FFFFFF, 32'h3F000000, 4'd13, 32'h00800000, 4'b0011);

      repeat (3) @(negedge clk);
      check_eq("rst_valid", 64'(out_valid), 64'd0);
      check_eq("rst_y", 64'(out_y), 64'd0);
      check_eq("rst_tag", 64'(out_tag), 64'd0);
      check_eq("rst_flags", 64'(out_flags), 64'd0);
      check_eq("rst_rdy_low", 64'(in_ready), 64'd0);
      rst = 1'b0;
      #1;
      check_eq("rst_rdy_after", 64'(in_ready), 64'd1);

      foreach (vecs[i])
         run_op(vecs[i].nm, vecs[i].a, vecs[i].b, vecs[i].tg, vecs[i].y, vecs[i].fl);

      // Backpressure: 1.0 * b is exactly b, results must arrive in issue order.
      @(negedge clk);
      issued = 0; head = 0; cyc = 0;
      while (head < 10 && cyc < 300) begin
         @(negedge clk);
         out_ready = bp_pat[cyc % 7];
         #1;
         if (out_valid) begin
            check_eq("bp_y", 64'(out_y), 64'(32'h40000000 | (head << 20)));
            check_eq("bp_tag", 64'(out_tag), 64'(head));
            if (!out_ready)
               check_eq("bp_stall_rdy", 64'(in_ready), 64'd0);
            else
               head++;
         end
         if (issued < 10) begin
            in_valid = 1'b1;
            in_a     = 32'h3F800000;
            in_b     = 32'h40000000 | (issued << 20);
            in_tag   = 4'(issued);
            if (in_ready)
               issued++;
         end else begin
            in_valid = 1'b0;
         end
         cyc++;
      end
      in_valid = 1'b0;
      check_eq("bp_count", 64'(head), 64'd10);
      out_ready = 1'b1;
      extra = 0;
      repeat (8) begin
         @(negedge clk);
         #1;
         if (out_valid) extra++;
      end
      check_eq("bp_extra", 64'(extra), 64'd0);

      // Reset with three operations in flight.
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_a     = 32'h3F800000;
         in_b     = 32'h40400000;
         in_tag   = 4'(10 + k);
      end
      @(negedge clk);
      in_valid = 1'b0;
      rst      = 1'b1;
      #1;
      check_eq("mid_rst_rdy_low", 64'(in_ready), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_eq("mid_rst_valid", 64'(out_valid), 64'd0);
      check_eq("mid_rst_rdy", 64'(in_ready), 64'd1);
      stale = 0;
      repeat (8) begin
         @(negedge clk);
         #1;
         if (out_valid) stale++;
      end
      check_eq("mid_rst_stale", 64'(stale), 64'd0);
      run_op("post_rst", 32'h40400000, 32'h40000000, 4'd7, 32'h40C00000, 4'b0000);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
